// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bundle of every bus signal around the two-port to one-port memory arbiter.
//
// CPU side (requesters):
//   i_read, i_address                                  fetch request
//   i_readdata, i_ready                                fetch response
//   d_read, d_write, d_byteenable, d_address,
//   d_writedata                                        load/store request
//   d_readdata, d_ready                                load/store response
// Memory side (Avalon-style master port):
//   read, write, byteenable, address, writedata        master command
//   readdata, waitrequest                              slave response / stall
// Status:
//   timeout                                            sticky watchdog flag
//
// Modports:
//   master : the arbiter itself (it is the master of the memory bus)
//   slave  : the environment, i.e. CPU core plus memory slave
// -----------------------------------------------------------------------------
interface mem_arbiter_if;
  // Instruction-fetch port
  logic        i_read;
  logic [31:0] i_address;
  logic [31:0] i_readdata;
  logic        i_ready;

  // Load/store port
  logic        d_read;
  logic        d_write;
  logic [3:0]  d_byteenable;
  logic [31:0] d_address;
  logic [31:0] d_writedata;
  logic [31:0] d_readdata;
  logic        d_ready;

  // Merged master port
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        waitrequest;

  // Watchdog
  logic        timeout;

  modport master (
    input  i_read, i_address,
    input  d_read, d_write, d_byteenable, d_address, d_writedata,
    input  readdata, waitrequest,
    output i_readdata, i_ready,
    output d_readdata, d_ready,
    output read, write, byteenable, address, writedata,
    output timeout
  );

  modport slave (
    output i_read, i_address,
    output d_read, d_write, d_byteenable, d_address, d_writedata,
    output readdata, waitrequest,
    input  i_readdata, i_ready,
    input  d_readdata, d_ready,
    input  read, write, byteenable, address, writedata,
    input  timeout
  );
endinterface : mem_arbiter_if

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Merges the CPU instruction-fetch port and load/store data port onto a single
// Avalon-style master port. One transaction is outstanding at a time; the
// master strobes are only ever high in ISSUE.
//
// Parameters:
//   ROUND_ROBIN : 1 = alternate grants on contention, 0 = data port always wins
//   WAIT_LIMIT  : waitrequest cycles tolerated in ISSUE before timeout sets;
//                 0 disables the watchdog
//
// Ports:
//   clk    : clock, all state changes on the rising edge
//   reset  : synchronous, active-high
//   bus    : mem_arbiter_if.master (request ports, master port, timeout)
//
// Sequence per transaction:
//   IDLE -> ISSUE (stalls while waitrequest) -> WAIT_DATA (reads only) -> RESP
//   All outputs, including the strobes and ready pulses, come from registers.
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int          ROUND_ROBIN = 1,
  parameter int unsigned WAIT_LIMIT  = 32'd0
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DATA = 2'd2,
    ST_RESP      = 2'd3
  } state_t;

  localparam bit          RR_EN    = (ROUND_ROBIN != 0);
  localparam bit          WD_EN    = (WAIT_LIMIT != 32'd0);
  localparam logic [31:0] CNT_MAX  = 32'hFFFF_FFFF;
  localparam logic [31:0] WD_LIMIT = WAIT_LIMIT;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t      r_state;
  logic        r_grant_d;       // 1 = data port owns the current transaction
  logic        r_last_grant_d;  // 1 = data port was granted most recently
  logic        r_is_write;
  logic        r_read;
  logic        r_write;
  logic [3:0]  r_byteenable;
  logic [31:0] r_address;
  logic [31:0] r_writedata;
  logic [31:0] r_i_readdata;
  logic [31:0] r_d_readdata;
  logic        r_i_ready;
  logic        r_d_ready;
  logic [31:0] r_wait_cnt;
  logic        r_timeout;

  // ---------------------------------------------------------------------------
  // Next-state wires
  // ---------------------------------------------------------------------------
  state_t      w_state_nxt;
  logic        w_grant_d_nxt;
  logic        w_last_grant_d_nxt;
  logic        w_is_write_nxt;
  logic        w_read_nxt;
  logic        w_write_nxt;
  logic [3:0]  w_byteenable_nxt;
  logic [31:0] w_address_nxt;
  logic [31:0] w_writedata_nxt;
  logic [31:0] w_i_readdata_nxt;
  logic [31:0] w_d_readdata_nxt;
  logic        w_i_ready_nxt;
  logic        w_d_ready_nxt;
  logic [31:0] w_wait_cnt_nxt;
  logic        w_timeout_nxt;

  // Arbitration helpers
  logic        w_pend_i;
  logic        w_pend_d;
  logic        w_pick_d;
  logic        w_d_is_write;
  logic [31:0] w_wait_cnt_inc;

  // Pending requests and the grant decision for this IDLE cycle
  always_comb begin
    w_pend_i     = bus.i_read;
    w_pend_d     = bus.d_read | bus.d_write;
    // A simultaneous load and store request is treated as a store.
    w_d_is_write = bus.d_write;
    w_pick_d     = 1'b0;
    if (w_pend_i && w_pend_d) begin
      // Tie: round-robin hands the grant to whichever port lost last time;
      // fixed priority always favours the data port.
      if (RR_EN) begin
        w_pick_d = ~r_last_grant_d;
      end else begin
        w_pick_d = 1'b1;
      end
    end else begin
      w_pick_d = w_pend_d;
    end
  end

  // Saturating increment of the stall counter so it can never wrap to zero
  always_comb begin
    if (r_wait_cnt != CNT_MAX) begin
      w_wait_cnt_inc = r_wait_cnt + 32'd1;
    end else begin
      w_wait_cnt_inc = r_wait_cnt;
    end
  end

  // Next-state and next-output logic of the transaction FSM
  always_comb begin
    w_state_nxt        = r_state;
    w_grant_d_nxt      = r_grant_d;
    w_last_grant_d_nxt = r_last_grant_d;
    w_is_write_nxt     = r_is_write;
    w_read_nxt         = 1'b0;
    w_write_nxt        = 1'b0;
    w_byteenable_nxt   = r_byteenable;
    w_address_nxt      = r_address;
    w_writedata_nxt    = r_writedata;
    w_i_readdata_nxt   = r_i_readdata;
    w_d_readdata_nxt   = r_d_readdata;
    w_i_ready_nxt      = 1'b0;
    w_d_ready_nxt      = 1'b0;
    w_wait_cnt_nxt     = r_wait_cnt;
    w_timeout_nxt      = r_timeout;

    case (r_state)
      ST_IDLE: begin
        if (w_pend_i || w_pend_d) begin
          w_state_nxt        = ST_ISSUE;
          w_grant_d_nxt      = w_pick_d;
          w_last_grant_d_nxt = w_pick_d;
          w_wait_cnt_nxt     = 32'd0;
          if (w_pick_d) begin
            w_is_write_nxt = w_d_is_write;
            w_address_nxt  = bus.d_address;
            if (w_d_is_write) begin
              w_byteenable_nxt = bus.d_byteenable;
              w_writedata_nxt  = bus.d_writedata;
            end else begin
              w_byteenable_nxt = 4'b1111;
              w_writedata_nxt  = 32'd0;
            end
          end else begin
            w_is_write_nxt   = 1'b0;
            w_address_nxt    = bus.i_address;
            w_byteenable_nxt = 4'b1111;
            w_writedata_nxt  = 32'd0;
          end
          // Strobes are registered, so they are raised on entry to ISSUE.
          w_read_nxt  = ~w_is_write_nxt;
          w_write_nxt = w_is_write_nxt;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_ISSUE: begin
        if (!bus.waitrequest) begin
          // Accepted: drop strobes and clear the watchdog count.
          w_wait_cnt_nxt = 32'd0;
          if (r_is_write) begin
            // Writes have no data phase; complete straight away.
            w_state_nxt   = ST_RESP;
            w_d_ready_nxt = r_grant_d;
            w_i_ready_nxt = ~r_grant_d;
          end else begin
            w_state_nxt = ST_WAIT_DATA;
          end
        end else begin
          // Stalled: hold the command and count the stall cycle.
          w_state_nxt    = ST_ISSUE;
          w_read_nxt     = r_read;
          w_write_nxt    = r_write;
          w_wait_cnt_nxt = w_wait_cnt_inc;
          if (WD_EN && (w_wait_cnt_inc >= WD_LIMIT)) begin
            w_timeout_nxt = 1'b1;
          end else begin
            w_timeout_nxt = r_timeout;
          end
        end
      end

      ST_WAIT_DATA: begin
        // Slave data is valid in this cycle; waitrequest is not looked at.
        w_state_nxt = ST_RESP;
        if (r_grant_d) begin
          w_d_readdata_nxt = bus.readdata;
          w_d_ready_nxt    = 1'b1;
        end else begin
          w_i_readdata_nxt = bus.readdata;
          w_i_ready_nxt    = 1'b1;
        end
      end

      ST_RESP: begin
        // Ready pulse is visible this cycle; requests are sampled next cycle.
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_grant_d      <= 1'b0;
      r_last_grant_d <= 1'b1;
      r_is_write     <= 1'b0;
      r_read         <= 1'b0;
      r_write        <= 1'b0;
      r_byteenable   <= 4'd0;
      r_address      <= 32'd0;
      r_writedata    <= 32'd0;
      r_i_readdata   <= 32'd0;
      r_d_readdata   <= 32'd0;
      r_i_ready      <= 1'b0;
      r_d_ready      <= 1'b0;
      r_wait_cnt     <= 32'd0;
      r_timeout      <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_grant_d      <= w_grant_d_nxt;
      r_last_grant_d <= w_last_grant_d_nxt;
      r_is_write     <= w_is_write_nxt;
      r_read         <= w_read_nxt;
      r_write        <= w_write_nxt;
      r_byteenable   <= w_byteenable_nxt;
      r_address      <= w_address_nxt;
      r_writedata    <= w_writedata_nxt;
      r_i_readdata   <= w_i_readdata_nxt;
      r_d_readdata   <= w_d_readdata_nxt;
      r_i_ready      <= w_i_ready_nxt;
      r_d_ready      <= w_d_ready_nxt;
      r_wait_cnt     <= w_wait_cnt_nxt;
      r_timeout      <= w_timeout_nxt;
    end
  end

  // Drive the interface straight from registers
  assign bus.read       = r_read;
  assign bus.write      = r_write;
  assign bus.byteenable = r_byteenable;
  assign bus.address    = r_address;
  assign bus.writedata  = r_writedata;
  assign bus.i_readdata = r_i_readdata;
  assign bus.i_ready    = r_i_ready;
  assign bus.d_readdata = r_d_readdata;
  assign bus.d_ready    = r_d_ready;
  assign bus.timeout    = r_timeout;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Two arbiters driven by identical stimulus:
//   u_rr : ROUND_ROBIN=1, WAIT_LIMIT=4
//   u_fp : ROUND_ROBIN=0, WAIT_LIMIT=0 (watchdog disabled)
// Inputs are driven 1 time unit after each rising edge; outputs are checked
// at the same point, so each check sees the cycle that edge started.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  mem_arbiter_if ifa();
  mem_arbiter_if ifb();

  // Second DUT sees exactly the same requests and slave behaviour.
  assign ifb.i_read       = ifa.i_read;
  assign ifb.i_address    = ifa.i_address;
  assign ifb.d_read       = ifa.d_read;
  assign ifb.d_write      = ifa.d_write;
  assign ifb.d_byteenable = ifa.d_byteenable;
  assign ifb.d_address    = ifa.d_address;
  assign ifb.d_writedata  = ifa.d_writedata;
  assign ifb.readdata     = ifa.readdata;
  assign ifb.waitrequest  = ifa.waitrequest;

  mem_arbiter #(.ROUND_ROBIN(1), .WAIT_LIMIT(4)) u_rr (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa)
  );

  mem_arbiter #(.ROUND_ROBIN(0), .WAIT_LIMIT(0)) u_fp (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors          = 0;
    miscompares      = 0;
    reset            = 1'b1;
    ifa.i_read       = 1'b0;
    ifa.i_address    = 32'd0;
    ifa.d_read       = 1'b0;
    ifa.d_write      = 1'b0;
    ifa.d_byteenable = 4'd0;
    ifa.d_address    = 32'd0;
    ifa.d_writedata  = 32'd0;
    ifa.readdata     = 32'd0;
    ifa.waitrequest  = 1'b0;

    // ---- reset state ----
    tick();
    tick();
    chk("rst_read",       ifa.read,       32'd0);
    chk("rst_write",      ifa.write,      32'd0);
    chk("rst_be",         ifa.byteenable, 32'd0);
    chk("rst_addr",       ifa.address,    32'd0);
    chk("rst_wdata",      ifa.writedata,  32'd0);
    chk("rst_i_ready",    ifa.i_ready,    32'd0);
    chk("rst_d_ready",    ifa.d_ready,    32'd0);
    chk("rst_i_rdata",    ifa.i_readdata, 32'd0);
    chk("rst_d_rdata",    ifa.d_readdata, 32'd0);
    chk("rst_timeout",    ifa.timeout,    32'd0);
    reset = 1'b0;

    // ---- single fetch, no stall: cycle 0 IDLE ----
    ifa.i_read    = 1'b1;
    ifa.i_address = 32'hBFC0_0000;
    ifa.readdata  = 32'h3C08_DEAD;
    chk("f_c0_read", ifa.read, 32'd0);
    tick();  // cycle 1 ISSUE
    chk("f_c1_read",  ifa.read,       32'd1);
    chk("f_c1_write", ifa.write,      32'd0);
    chk("f_c1_addr",  ifa.address,    32'hBFC0_0000);
    chk("f_c1_be",    ifa.byteenable, 32'hF);
    chk("f_c1_wdata", ifa.writedata,  32'd0);
    tick();  // cycle 2 WAIT_DATA
    chk("f_c2_read",    ifa.read,    32'd0);
    chk("f_c2_i_ready", ifa.i_ready, 32'd0);
    tick();  // cycle 3 RESP
    chk("f_c3_i_ready",  ifa.i_ready,    32'd1);
    chk("f_c3_i_rdata",  ifa.i_readdata, 32'h3C08_DEAD);
    chk("f_c3_d_ready",  ifa.d_ready,    32'd0);
    chk("f_c3_fp_ready", ifb.i_ready,    32'd1);
    ifa.i_read = 1'b0;
    tick();  // cycle 4 IDLE
    chk("f_c4_i_ready", ifa.i_ready,    32'd0);
    chk("f_c4_i_rdata", ifa.i_readdata, 32'h3C08_DEAD);

    // ---- store with three stall cycles ----
    ifa.d_write      = 1'b1;
    ifa.d_address    = 32'hBFC0_0010;
    ifa.d_byteenable = 4'b0011;
    ifa.d_writedata  = 32'h1234_ABCD;
    ifa.waitrequest  = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();  // cycles 1..4 ISSUE
      chk("st_write", ifa.write,      32'd1);
      chk("st_read",  ifa.read,       32'd0);
      chk("st_addr",  ifa.address,    32'hBFC0_0010);
      chk("st_be",    ifa.byteenable, 32'h3);
      chk("st_wdata", ifa.writedata,  32'h1234_ABCD);
      chk("st_d_ready_early", ifa.d_ready, 32'd0);
      if (k == 4) begin
        ifa.waitrequest = 1'b0;
      end else begin
        ifa.waitrequest = 1'b1;
      end
    end
    tick();  // cycle 5 RESP
    chk("st_c5_d_ready", ifa.d_ready,    32'd1);
    chk("st_c5_write",   ifa.write,      32'd0);
    chk("st_c5_d_rdata", ifa.d_readdata, 32'd0);
    chk("st_c5_timeout", ifa.timeout,    32'd0);
    ifa.d_write = 1'b0;
    tick();  // IDLE
    chk("st_c6_d_ready", ifa.d_ready, 32'd0);

    // ---- contention: fetch and load held together ----
    ifa.i_read    = 1'b1;
    ifa.i_address = 32'h0000_0100;
    ifa.d_read    = 1'b1;
    ifa.d_address = 32'h0000_0200;
    ifa.readdata  = 32'hCAFE_F00D;
    for (int n = 0; n < 4; n++) begin
      tick();  // ISSUE
      chk("cn_rr_addr", ifa.address, (n % 2 == 1) ? 32'h0000_0200 : 32'h0000_0100);
      chk("cn_fp_addr", ifb.address, 32'h0000_0200);
      tick();  // WAIT_DATA
      tick();  // RESP
      chk("cn_rr_i_ready", ifa.i_ready, (n % 2 == 1) ? 32'd0 : 32'd1);
      chk("cn_rr_d_ready", ifa.d_ready, (n % 2 == 1) ? 32'd1 : 32'd0);
      chk("cn_fp_d_ready", ifb.d_ready, 32'd1);
      chk("cn_fp_i_ready", ifb.i_ready, 32'd0);
      tick();  // IDLE
      chk("cn_rr_pulse_end", {31'd0, ifa.i_ready | ifa.d_ready}, 32'd0);
    end
    ifa.i_read = 1'b0;
    ifa.d_read = 1'b0;
    tick();
    chk("cn_rr_i_rdata", ifa.i_readdata, 32'hCAFE_F00D);
    chk("cn_rr_d_rdata", ifa.d_readdata, 32'hCAFE_F00D);
    chk("cn_fp_i_rdata", ifb.i_readdata, 32'h3C08_DEAD);

    // ---- watchdog: waitrequest stuck, then released ----
    ifa.i_read      = 1'b1;
    ifa.i_address   = 32'h0000_0040;
    ifa.readdata    = 32'h55AA_55AA;
    ifa.waitrequest = 1'b1;
    tick();  // ISSUE cycle 1
    for (int k = 1; k <= 4; k++) begin
      chk("wd_pre_timeout", ifa.timeout, 32'd0);
      chk("wd_read_held",   ifa.read,    32'd1);
      tick();
    end
    chk("wd_timeout_set", ifa.timeout, 32'd1);
    chk("wd_fp_disabled", ifb.timeout, 32'd0);
    chk("wd_still_issue", ifa.read,    32'd1);
    ifa.waitrequest = 1'b0;
    tick();  // WAIT_DATA
    tick();  // RESP
    chk("wd_i_ready", ifa.i_ready,    32'd1);
    chk("wd_i_rdata", ifa.i_readdata, 32'h55AA_55AA);
    ifa.i_read = 1'b0;
    tick();  // IDLE
    chk("wd_sticky",     ifa.timeout, 32'd1);
    chk("wd_fp_sticky0", ifb.timeout, 32'd0);

    // ---- reset in WAIT_DATA ----
    ifa.d_read    = 1'b1;
    ifa.d_address = 32'h0000_0080;
    ifa.readdata  = 32'h7777_7777;
    tick();  // ISSUE
    tick();  // WAIT_DATA
    reset = 1'b1;
    tick();  // IDLE after reset
    chk("rw_d_ready", ifa.d_ready,    32'd0);
    chk("rw_read",    ifa.read,       32'd0);
    chk("rw_addr",    ifa.address,    32'd0);
    chk("rw_be",      ifa.byteenable, 32'd0);
    chk("rw_d_rdata", ifa.d_readdata, 32'd0);
    chk("rw_i_rdata", ifa.i_readdata, 32'd0);
    chk("rw_timeout", ifa.timeout,    32'd0);
    reset        = 1'b0;
    ifa.readdata = 32'h1234_5678;
    tick();  // ISSUE
    chk("rw_new_read",  ifa.read,    32'd1);
    chk("rw_new_addr",  ifa.address, 32'h0000_0080);
    chk("rw_no_ready",  ifa.d_ready, 32'd0);
    tick();  // WAIT_DATA
    chk("rw_no_ready2", ifa.d_ready, 32'd0);
    tick();  // RESP
    chk("rw_d_ready_new",  ifa.d_ready,    32'd1);
    chk("rw_d_rdata_new",  ifa.d_readdata, 32'h1234_5678);
    chk("rw_fp_rdata_new", ifb.d_readdata, 32'h1234_5678);
    ifa.d_read = 1'b0;
    tick();
    chk("rw_end_ready", ifa.d_ready, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_mem_arbiter

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port to one-port memory bus arbiter between the MIPS CPU core and the Avalon-style memory slave (`cpu_ram` in simulation, real memory in synthesis). Merges the instruction-fetch port and the load/store data port onto one master port. Stalls the master port on `waitrequest`, returns read data and a one-cycle `ready` pulse to the granted requester, and arbitrates round-robin or fixed-priority.

## Interface
Parameters:
- `ROUND_ROBIN`, 1: 1 = alternate on contention; 0 = data port always wins.
- `WAIT_LIMIT`, 0: `waitrequest` cycles tolerated in ISSUE before `timeout` sets; 0 disables the watchdog.

Ports. One clock; reset is synchronous and active-high.
- `clk` in 1: clock, all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `i_read` in 1: fetch request, held until `i_ready`.
- `i_address` in 32: fetch byte address, word aligned.
- `i_readdata` out 32: fetched word, registered.
- `i_ready` out 1: one-cycle completion pulse.
- `d_read` in 1: load request, held until `d_ready`.
- `d_write` in 1: store request, held until `d_ready`.
- `d_byteenable` in 4: store lane mask.
- `d_address` in 32: data address, word aligned.
- `d_writedata` in 32: store data.
- `d_readdata` out 32: loaded word, registered.
- `d_ready` out 1: one-cycle completion pulse.
- `read` out 1: master read strobe.
- `write` out 1: master write strobe.
- `byteenable` out 4: master lane mask.
- `address` out 32: master address.
- `writedata` out 32: master write data.
- `readdata` in 32: slave read data, valid the cycle after acceptance.
- `waitrequest` in 1: slave stall.
- `timeout` out 1: sticky watchdog flag.

## Operation
- State machine: IDLE, ISSUE, WAIT_DATA, RESP.
- IDLE:
  - A pending request is `i_read`, or `d_read` or `d_write`.
  - If none is pending, stay in IDLE.
  - Otherwise grant one port, latch op, address, byteenable and writedata into registers, then go to ISSUE.
- Arbitration on contention:
  - `ROUND_ROBIN`=1: grant the port not granted last. `last_grant` resets to DATA, so the first tie after reset goes to fetch.
  - `ROUND_ROBIN`=0: data wins every tie.
- Latched master fields:
  - Reads drive `byteenable`=4'b1111 and `writedata`=0.
  - If `d_read` and `d_write` are both high, the transaction is a write.
- ISSUE:
  - `read` or `write` is high, derived from state and the latched op. All other master outputs are constant from the latch.
  - An edge with `waitrequest`=0 accepts the transaction. Writes go to RESP; reads go to WAIT_DATA.
  - An edge with `waitrequest`=1 keeps the state in ISSUE with all fields unchanged.
- WAIT_DATA:
  - `read`=`write`=0.
  - At the edge, capture `readdata` into the granted port's `*_readdata`, then go to RESP.
  - `waitrequest` is ignored in this state.
- RESP:
  - Granted port's `*_ready`=1 for exactly this cycle.
  - Requests are not sampled. Next state is IDLE.
  - A requester still asserting its request in the following IDLE cycle starts a new transaction.
- Readdata registers:
  - `*_readdata` holds its value until the next read completes on that port.
  - Writes leave `d_readdata` unchanged.
- Watchdog:
  - A counter increments on each ISSUE cycle with `waitrequest`=1 and clears on acceptance.
  - When the counter reaches `WAIT_LIMIT` (nonzero), `timeout` sets.
  - `timeout` stays set until reset. The transaction still completes if the stall later clears.

## Timing
- Reset values:
  - State IDLE; `read`, `write`, `i_ready`, `d_ready`, `timeout` = 0.
  - `byteenable`, `address`, `writedata`, `i_readdata`, `d_readdata` = 0.
  - Watchdog counter 0; `last_grant`=DATA.
- Read latency with no stalls: request seen in IDLE at cycle 0; ISSUE cycle 1; WAIT_DATA cycle 2; `ready` and valid data in cycle 3.
- Write latency with no stalls: ready in cycle 2.
- Each `waitrequest`=1 cycle in ISSUE adds exactly one cycle.
- Reset mid-transaction: takes effect on that edge. Any outstanding read is abandoned without a `ready` pulse, and the next cycle is IDLE with strobes low.
- Master strobes are never high outside ISSUE, so at most one transaction is outstanding.
- Request inputs are sampled only in IDLE. Changes during ISSUE, WAIT_DATA or RESP are ignored.

## Test plan
- Single fetch, `waitrequest`=0, `i_address`=0xBFC00000, slave returns 0x3C08DEAD: `read` high in cycle 1 only; `i_ready` high in cycle 3 with `i_readdata`=0x3C08DEAD; `d_ready` stays 0.
- Store, `d_address`=0xBFC00010, `d_byteenable`=4'b0011, `d_writedata`=0x1234ABCD, with `waitrequest` high for 3 cycles: `write` high for 4 cycles with fields unchanged throughout; `d_ready` in cycle 5.
- Fetch and load asserted together and held for repeated transactions, `ROUND_ROBIN`=1: grants go I, D, I, D; each port sees exactly one `ready` per transaction.
- Same contention with `ROUND_ROBIN`=0: data is granted every time both requests are present.
- `WAIT_LIMIT`=4 with `waitrequest` stuck at 1: `timeout` rises after 4 ISSUE stall cycles. When `waitrequest` is released, the transaction completes and `timeout` stays 1 until reset.
- Reset asserted in WAIT_DATA: the next cycle is IDLE with all outputs at reset values and no `ready` pulse; a new request afterwards completes normally.
